note_mapper: RTL and testbench
==============================

NOTE_MAPPER -- requirements
Module: note_mapper

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 10: FFT bin index width.
REQ-002 SHALL have parameter NOTE_WIDTH, default 6: note index width; table depth NUM_NOTES = 2**NOTE_WIDTH.
REQ-003 SHALL have parameter HOLD_FRAMES, default 3, range 1..15: consecutive identical lookups needed to change the stable note.
REQ-004 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port bin_index_in  input  BIN_WIDTH  bin to look up.
REQ-007 SHALL have port valid_in  input  1  bin_index_in valid.
REQ-008 SHALL have port ready_out  output  1  lookup can be accepted.
REQ-009 SHALL have port cfg_we_in  input  1  table write strobe.
REQ-010 SHALL have port cfg_addr_in  input  NOTE_WIDTH  table entry to write.
REQ-011 SHALL have port cfg_data_in  input  BIN_WIDTH  lower-bound bin for that note.
REQ-012 SHALL have port note_index_out  output  NOTE_WIDTH  raw lookup result.
REQ-013 SHALL have port in_range_out  output  1  bin at or above lower_bound[0].
REQ-014 SHALL have port valid_out  output  1  one-cycle pulse qualifying note_index_out/in_range_out.
REQ-015 SHALL have port stable_note_out  output  NOTE_WIDTH  debounced note.
REQ-016 SHALL have port stable_valid_out  output  1  a debounced note is present (0 = silence).
REQ-017 SHALL have port note_change_out  output  1  one-cycle pulse when stable_note_out/stable_valid_out change.

Function
REQ-018 SHALL hold table lower_bound[0..NUM_NOTES-1]; software keeps it ascending; lookup result = largest i with lower_bound[i] <= bin; if none, note 0 with in_range_out=0.
REQ-019 SHALL implement FSM IDLE -> SEARCH -> DONE -> IDLE; ready_out=1 only in IDLE.
REQ-020 SHALL accept a lookup on the edge where valid_in && ready_out, latching bin_index_in and moving to SEARCH with result=0.
REQ-021 SHALL in SEARCH perform NOTE_WIDTH binary-search steps, one per cycle, MSB first: cand = result | (1<<k); keep cand if lower_bound[cand] <= latched bin.
REQ-022 SHALL after the last step enter DONE for exactly one cycle with valid_out=1; in_range_out = (lower_bound[0] <= latched bin); valid_out asserts NOTE_WIDTH+1 cycles after the accept edge (7 at default).
REQ-023 SHALL hold note_index_out and in_range_out stable from DONE until the next DONE.
REQ-024 SHALL write lower_bound[cfg_addr_in] = cfg_data_in on an edge with cfg_we_in=1 only in IDLE; writes in SEARCH/DONE SHALL be ignored.
REQ-025 SHALL, for a write and accept on the same IDLE edge, perform both; the search SHALL see the new value.
REQ-026 SHALL run debounce on the edge ending DONE: result key = (in_range, note); if key equals candidate key, count increments saturating at HOLD_FRAMES, else candidate=key, count=1.
REQ-027 SHALL, when count reaches HOLD_FRAMES and candidate differs from current stable state, set stable_valid_out=candidate in_range, stable_note_out=candidate note (0 if out of range), and pulse note_change_out for one cycle aligned with the new values.
REQ-028 SHALL not pulse note_change_out when the qualified candidate equals the current stable state.

Reset
REQ-029 SHALL on rst_in=1 return to IDLE from any state, abort any search without valid_out, set lower_bound[i]=i, and clear all outputs except ready_out=1 after reset; candidate=out-of-range, count=0.
REQ-030 SHALL ignore valid_in and cfg_we_in during reset cycles.

Verification
REQ-031 After reset, bin 10 with valid_in -> ready_out low 8 cycles, valid_out pulse 7 cycles after accept, note 10, in_range 1.
REQ-032 After reset, bin 200 -> note 63, in_range 1; write lower_bound[0]=5 then bin 3 -> note 0, in_range 0.
REQ-033 Lookups 10,10,12,10,10,10 -> stable_valid rises, stable_note=10 one cycle after the 6th valid_out, single note_change pulse; three further 10s -> no pulse.
REQ-034 Three out-of-range lookups after stable note 10 -> stable_valid 0, stable_note 0, one note_change pulse.
REQ-035 cfg_we_in with addr 10 data 40 during SEARCH -> ignored; later bin 10 -> note 10.
REQ-036 rst_in asserted mid-SEARCH -> no valid_out, ready_out 1 cycle after reset release, table identity, stable_valid 0.

Source files
------------

// File: rtl/note_mapper.sv
// Maps an FFT bin index to a note index by binary search over a writable
// ascending table of lower-bound bins, then debounces the result into a stable note.
module note_mapper #(
  parameter int BIN_WIDTH   = 10,
  parameter int NOTE_WIDTH  = 6,
  parameter int HOLD_FRAMES = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [BIN_WIDTH-1:0]  bin_index_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  cfg_we_in,
  input  logic [NOTE_WIDTH-1:0] cfg_addr_in,
  input  logic [BIN_WIDTH-1:0]  cfg_data_in,
  output logic [NOTE_WIDTH-1:0] note_index_out,
  output logic                  in_range_out,
  output logic                  valid_out,
  output logic [NOTE_WIDTH-1:0] stable_note_out,
  output logic                  stable_valid_out,
  output logic                  note_change_out
);

  localparam int         NUM_NOTES = 2 ** NOTE_WIDTH;
  localparam int         STEP_W    = (NOTE_WIDTH > 1) ? $clog2(NOTE_WIDTH) : 1;
  localparam logic [3:0] HOLD_CNT  = 4'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [BIN_WIDTH-1:0]  lower_bound_r [NUM_NOTES];
  logic [BIN_WIDTH-1:0]  bin_r;
  logic [NOTE_WIDTH-1:0] result_r;
  logic [STEP_W-1:0]     step_r;
  logic                  check_r;
  logic                  in_range_r;
  logic [NOTE_WIDTH-1:0] cand_s;
  logic                  keep_s;
  logic [NOTE_WIDTH-1:0] result_next_s;

  logic [NOTE_WIDTH-1:0] note_index_r;
  logic                  in_range_out_r;
  logic                  valid_r;
  logic                  ready_r;

  logic [NOTE_WIDTH:0]   key_s;
  logic [NOTE_WIDTH:0]   cand_key_r;
  logic [3:0]            cnt_r;
  logic [3:0]            cnt_next_s;
  logic                  qualify_s;
  logic [NOTE_WIDTH-1:0] stable_note_r;
  logic                  stable_valid_r;
  logic                  change_r;

  // One binary-search step: try setting bit step_r of the partial result.
  always_comb begin
    cand_s        = result_r | (NOTE_WIDTH'(1) << step_r);
    keep_s        = (lower_bound_r[cand_s] <= bin_r);
    result_next_s = result_r;
    if (keep_s) begin
      result_next_s = cand_s;
    end else begin
      result_next_s = result_r;
    end
  end

  // Lookup sequencing: a range-check cycle, then one cycle per result bit.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_in) begin
          state_next_s = ST_SEARCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (!check_r && (step_r == STEP_W'(0))) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SEARCH;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, search datapath and registered lookup outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r        <= ST_IDLE;
      bin_r          <= '0;
      result_r       <= '0;
      step_r         <= '0;
      check_r        <= 1'b0;
      in_range_r     <= 1'b0;
      note_index_r   <= '0;
      in_range_out_r <= 1'b0;
      valid_r        <= 1'b0;
      ready_r        <= 1'b1;
    end else begin
      state_r <= state_next_s;
      valid_r <= (state_next_s == ST_DONE);
      ready_r <= (state_next_s == ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (valid_in) begin
            bin_r    <= bin_index_in;
            result_r <= '0;
            step_r   <= STEP_W'(NOTE_WIDTH - 1);
            check_r  <= 1'b1;
          end
        end
        ST_SEARCH: begin
          if (check_r) begin
            in_range_r <= (lower_bound_r[0] <= bin_r);
            check_r    <= 1'b0;
          end else begin
            result_r <= result_next_s;
            if (step_r == STEP_W'(0)) begin
              // A bin below the whole table reports note 0, whatever the search found.
              note_index_r   <= in_range_r ? result_next_s : '0;
              in_range_out_r <= in_range_r;
            end else begin
              step_r <= step_r - STEP_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Lower-bound table; software may only rewrite it while the mapper is idle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        lower_bound_r[i] <= BIN_WIDTH'(i);
      end
    end else if (cfg_we_in && (state_r == ST_IDLE)) begin
      lower_bound_r[cfg_addr_in] <= cfg_data_in;
    end
  end

  // Debounce bookkeeping for the result presented in DONE.
  always_comb begin
    key_s      = {in_range_out_r, note_index_r};
    cnt_next_s = 4'd1;
    qualify_s  = 1'b0;
    if (key_s == cand_key_r) begin
      cnt_next_s = (cnt_r >= HOLD_CNT) ? HOLD_CNT : (cnt_r + 4'd1);
    end else begin
      cnt_next_s = 4'd1;
    end
    if ((cnt_next_s == HOLD_CNT) && (key_s != {stable_valid_r, stable_note_r})) begin
      qualify_s = 1'b1;
    end else begin
      qualify_s = 1'b0;
    end
  end

  // Candidate/stable registers, updated on the edge that ends DONE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cand_key_r     <= '0;
      cnt_r          <= 4'd0;
      stable_note_r  <= '0;
      stable_valid_r <= 1'b0;
      change_r       <= 1'b0;
    end else begin
      change_r <= 1'b0;
      if (state_r == ST_DONE) begin
        cand_key_r <= key_s;
        cnt_r      <= cnt_next_s;
        if (qualify_s) begin
          stable_valid_r <= key_s[NOTE_WIDTH];
          stable_note_r  <= key_s[NOTE_WIDTH-1:0];
          change_r       <= 1'b1;
        end
      end
    end
  end

  assign ready_out        = ready_r;
  assign valid_out        = valid_r;
  assign note_index_out   = note_index_r;
  assign in_range_out     = in_range_out_r;
  assign stable_note_out  = stable_note_r;
  assign stable_valid_out = stable_valid_r;
  assign note_change_out  = change_r;

endmodule

// File: tb/tb_note_mapper.sv
// Scoreboard bench for note_mapper: lookups push expected results, and a
// negedge monitor pops and compares whenever valid_out or note_change_out pulses.
module tb_note_mapper;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [9:0] bin_index_in;
  logic       valid_in;
  logic       ready_out;
  logic       cfg_we_in;
  logic [5:0] cfg_addr_in;
  logic [9:0] cfg_data_in;
  logic [5:0] note_index_out;
  logic       in_range_out;
  logic       valid_out;
  logic [5:0] stable_note_out;
  logic       stable_valid_out;
  logic       note_change_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int note;
    int rng;
    int due;
  } exp_t;

  exp_t vq[$];
  exp_t sq[$];

  note_mapper #(.BIN_WIDTH(10), .NOTE_WIDTH(6), .HOLD_FRAMES(3)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .bin_index_in     (bin_index_in),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .cfg_we_in        (cfg_we_in),
    .cfg_addr_in      (cfg_addr_in),
    .cfg_data_in      (cfg_data_in),
    .note_index_out   (note_index_out),
    .in_range_out     (in_range_out),
    .valid_out        (valid_out),
    .stable_note_out  (stable_note_out),
    .stable_valid_out (stable_valid_out),
    .note_change_out  (note_change_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of its queue.
  always @(negedge clk_in) begin
    exp_t e;
    if (valid_out) begin
      chk("valid_out_expected", int'(vq.size() > 0), 1);
      if (vq.size() > 0) begin
        e = vq.pop_front();
        chk("note_index", int'(note_index_out), e.note);
        chk("in_range", int'(in_range_out), e.rng);
        chk("valid_cycle", cyc, e.due);
      end
    end
    if (note_change_out) begin
      chk("note_change_expected", int'(sq.size() > 0), 1);
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("stable_note", int'(stable_note_out), e.note);
        chk("stable_valid", int'(stable_valid_out), e.rng);
        chk("change_cycle", cyc, e.due);
      end
    end
  end

  // mode 0: plain lookup; 1: write lower_bound[5]=9 on the accept edge;
  // 2: attempt write lower_bound[10]=40 during SEARCH.
  task automatic lookup(input int bin, input int en, input int er,
                        input int chg, input int sn, input int sv, input int mode);
    int   a;
    int   lat;
    exp_t e;
    lat = -1;
    for (int w = 0; w < 20 && !ready_out; w++) begin
      @(posedge clk_in); #1;
    end
    bin_index_in = 10'(bin);
    valid_in     = 1'b1;
    if (mode == 1) begin
      cfg_we_in   = 1'b1;
      cfg_addr_in = 6'd5;
      cfg_data_in = 10'd9;
    end
    @(posedge clk_in); #1;
    a         = cyc;
    valid_in  = 1'b0;
    cfg_we_in = 1'b0;
    if (mode == 2) begin
      cfg_we_in   = 1'b1;
      cfg_addr_in = 6'd10;
      cfg_data_in = 10'd40;
    end
    e.note = en; e.rng = er; e.due = a + 7;
    vq.push_back(e);
    if (chg != 0) begin
      e.note = sn; e.rng = sv; e.due = a + 8;
      sq.push_back(e);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_in); #1;
      if (k == 3) cfg_we_in = 1'b0;
      if (ready_out) begin
        lat = cyc - a;
        break;
      end
    end
    cfg_we_in = 1'b0;
    chk("ready_low_cycles", lat, 8);
    chk("note_hold", int'(note_index_out), en);
    chk("in_range_hold", int'(in_range_out), er);
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we_in   = 1'b1;
    cfg_addr_in = 6'(addr);
    cfg_data_in = 10'(data);
    @(posedge clk_in); #1;
    cfg_we_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in       = 1'b1;
    valid_in     = 1'b0;
    bin_index_in = 10'd0;
    cfg_we_in    = 1'b0;
    cfg_addr_in  = 6'd0;
    cfg_data_in  = 10'd0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_ready", int'(ready_out), 1);
    chk("reset_valid", int'(valid_out), 0);
    chk("reset_note", int'(note_index_out), 0);
    chk("reset_in_range", int'(in_range_out), 0);
    chk("reset_stable_valid", int'(stable_valid_out), 0);
    chk("reset_note_change", int'(note_change_out), 0);
    rst_in = 1'b0;

    // bin, note, in_range, change?, stable_note, stable_valid, mode
    lookup(10, 10, 1, 0, 0, 0, 0);
    lookup(10, 10, 1, 0, 0, 0, 0);
    lookup(12, 12, 1, 0, 0, 0, 0);
    lookup(10, 10, 1, 0, 0, 0, 0);
    lookup(10, 10, 1, 0, 0, 0, 0);
    lookup(10, 10, 1, 1, 10, 1, 0);
    lookup(10, 10, 1, 0, 0, 0, 0);
    lookup(10, 10, 1, 0, 0, 0, 0);
    lookup(10, 10, 1, 0, 0, 0, 0);
    lookup(200, 63, 1, 0, 0, 0, 0);
    cfg_write(0, 5);
    lookup(3, 0, 0, 0, 0, 0, 0);
    lookup(3, 0, 0, 0, 0, 0, 0);
    lookup(3, 0, 0, 1, 0, 0, 0);
    cfg_write(0, 0);
    lookup(50, 50, 1, 0, 0, 0, 2);
    lookup(10, 10, 1, 0, 0, 0, 0);
    lookup(0, 0, 1, 0, 0, 0, 0);
    lookup(5, 4, 1, 0, 0, 0, 1);

    // Reset in the middle of a search, with valid_in and cfg_we_in held high.
    bin_index_in = 10'd20;
    valid_in     = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    repeat (3) begin
      @(posedge clk_in); #1;
    end
    rst_in       = 1'b1;
    valid_in     = 1'b1;
    bin_index_in = 10'd7;
    cfg_we_in    = 1'b1;
    cfg_addr_in  = 6'd3;
    cfg_data_in  = 10'd99;
    repeat (2) begin
      @(posedge clk_in); #1;
    end
    rst_in    = 1'b0;
    valid_in  = 1'b0;
    cfg_we_in = 1'b0;
    @(posedge clk_in); #1;
    chk("post_reset_ready", int'(ready_out), 1);
    chk("post_reset_valid", int'(valid_out), 0);
    chk("post_reset_stable_valid", int'(stable_valid_out), 0);
    chk("post_reset_stable_note", int'(stable_note_out), 0);
    chk("post_reset_note", int'(note_index_out), 0);
    lookup(5, 5, 1, 0, 0, 0, 0);
    lookup(3, 3, 1, 0, 0, 0, 0);

    repeat (5) @(posedge clk_in);
    #1;
    chk("valid_queue_drained", vq.size(), 0);
    chk("change_queue_drained", sq.size(), 0);
    chk("final_stable_valid", int'(stable_valid_out), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
